commutator: RTL

COMMUTATOR -- requirements
Module: commutator

---
 rtl/ebike_pkg.sv | 47 ++++
 rtl/hall_sync.sv | 21 ++
 rtl/commutator.sv | 96 +++++++++
 3 files changed

// File: rtl/ebike_pkg.sv
// Shared e-bike motor-drive definitions: phase-select encoding, duty constants,
// commutation mode encoding and the Hall-code commutation table.
package ebike_pkg;

    typedef enum logic [1:0] {
        HIGH_Z    = 2'b00,
        REV_CURR  = 2'b01,
        FRWD_CURR = 2'b10,
        BRAKE     = 2'b11
    } sel_t;

    // Bit 1 alone marks STALL so the stall output is a direct flop bit.
    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_BRAKE = 2'b01,
        MODE_STALL = 2'b10
    } mode_t;

    typedef struct packed {
        sel_t grn;
        sel_t ylw;
        sel_t blu;
    } sel3_t;

    localparam logic [10:0] BRAKE_DUTY  = 11'h600;
    localparam logic [10:0] DUTY_OFFSET = 11'h400;

    function automatic logic hall_valid(input logic [2:0] rot);
        return (rot != 3'b000) && (rot != 3'b111);
    endfunction

    function automatic sel3_t commutate(input logic [2:0] rot);
        sel3_t s;
        s = '{grn: HIGH_Z, ylw: HIGH_Z, blu: HIGH_Z};
        case (rot)
            3'b101:  s = '{grn: FRWD_CURR, ylw: REV_CURR,  blu: HIGH_Z};
            3'b100:  s = '{grn: FRWD_CURR, ylw: HIGH_Z,    blu: REV_CURR};
            3'b110:  s = '{grn: HIGH_Z,    ylw: FRWD_CURR, blu: REV_CURR};
            3'b010:  s = '{grn: REV_CURR,  ylw: FRWD_CURR, blu: HIGH_Z};
            3'b011:  s = '{grn: REV_CURR,  ylw: HIGH_Z,    blu: FRWD_CURR};
            3'b001:  s = '{grn: HIGH_Z,    ylw: REV_CURR,  blu: FRWD_CURR};
            default: s = '{grn: HIGH_Z,    ylw: HIGH_Z,    blu: HIGH_Z};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hall_sync.sv
// Two-flop synchronizer bringing the three asynchronous Hall inputs into clk.
module hall_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hall_in,
    output logic [2:0] hall_out
);

    logic [2:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta     <= '0;
            hall_out <= '0;
        end else begin
            meta     <= hall_in;
            hall_out <= meta;
        end
    end

endmodule

// File: rtl/commutator.sv
// Six-step BLDC commutator: maps synchronized Hall code to phase selects and
// duty at PWM period starts, with immediate brake and stall detection.
module commutator
    import ebike_pkg::*;
#(
    parameter int STALL_PERIODS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        brake_n,
    input  logic [11:0] drive_mag,
    input  logic        PWM_synch,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        stall,
    output logic        hall_err
);

    localparam int CW = $clog2(STALL_PERIODS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STALL_PERIODS);

    logic [2:0]    rotation;
    logic [2:0]    last_rot;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] cnt_inc;
    mode_t         mode;
    logic          same, active, valid, stall_hit;
    sel3_t         comm;

    hall_sync u_hall_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .hall_in  ({hallGrn, hallYlw, hallBlu}),
        .hall_out (rotation)
    );

    assign stall = mode[1];

    always_comb begin
        same      = (rotation == last_rot);
        active    = (drive_mag != '0);
        valid     = hall_valid(rotation);
        cnt_inc   = (stall_cnt >= CNT_MAX) ? stall_cnt : stall_cnt + CW'(1);
        stall_hit = same && active && (cnt_inc >= CNT_MAX);
        comm      = commutate(rotation);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode      <= MODE_RUN;
            last_rot  <= '0;
            stall_cnt <= '0;
            hall_err  <= 1'b0;
            duty      <= '0;
            selGrn    <= HIGH_Z;
            selYlw    <= HIGH_Z;
            selBlu    <= HIGH_Z;
        end else if (!brake_n) begin
            mode      <= MODE_BRAKE;
            stall_cnt <= '0;
            hall_err  <= 1'b0;
            duty      <= BRAKE_DUTY;
            selGrn    <= BRAKE;
            selYlw    <= BRAKE;
            selBlu    <= BRAKE;
            if (PWM_synch)
                last_rot <= rotation;
        end else begin
            hall_err <= 1'b0;
            // Outside a PWM period start everything holds, including BRAKE after release.
            if (PWM_synch) begin
                last_rot  <= rotation;
                stall_cnt <= (same && active) ? cnt_inc : '0;
                mode      <= stall_hit ? MODE_STALL : MODE_RUN;
                if (!valid || stall_hit || !active) begin
                    hall_err <= !valid;
                    duty     <= '0;
                    selGrn   <= HIGH_Z;
                    selYlw   <= HIGH_Z;
                    selBlu   <= HIGH_Z;
                end else begin
                    duty   <= DUTY_OFFSET + {1'b0, drive_mag[11:2]};
                    selGrn <= comm.grn;
                    selYlw <= comm.ylw;
                    selBlu <= comm.blu;
                end
            end
        end
    end

endmodule
